// File: rtl/mul_scheduler_pkg.sv
// Shared types and constants for the multiplier scheduler: operand mask
// element type, p_det type, FSM state encoding and the p_det acceptance rule.
package mul_scheduler_pkg;

    // Masking order of the redundant representation
    localparam int D         = 2;
    // Number of mask bytes loaded per operation
    localparam int MASK_LEN  = 2 * (8 + D);
    // Width of the mask byte index
    localparam int IDX_W     = $clog2(MASK_LEN);
    // Candidates at or above this value are rejected
    localparam int P_DET_MAX = 30;

    typedef logic [4:0] p_det_t;
    typedef logic [7:0] red_poly_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        LOAD  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        RESP  = 3'd5
    } sched_state_t;

    // A random candidate is usable as p_det only below P_DET_MAX
    function automatic logic pdet_ok(input p_det_t cand);
        return (cand < 5'(P_DET_MAX));
    endfunction

endpackage

// File: rtl/mul_scheduler_if.sv
// Bundle of requester-side, random-source and multiplier-side signals of the
// scheduler. The slave modport is the scheduler's view, master the environment's.
interface mul_scheduler_if
    import mul_scheduler_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]         req_i;
    logic [N_REQ-1:0][15:0]   a_i;
    logic [N_REQ-1:0][15:0]   b_i;
    logic [N_REQ-1:0]         ack_o;
    logic                     err_o;
    logic [15:0]              res_o;
    logic [7:0]               rnd_i;
    logic                     rnd_valid_i;
    logic                     mul_drdy_o;
    logic [15:0]              mul_p1_o;
    logic [15:0]              mul_p2_o;
    p_det_t                   p_det_o;
    red_poly_t [0:MASK_LEN-1] random_vect_o;
    logic [15:0]              mul_out_i;
    logic                     mul_drdy_i;

    modport slave (
        input  req_i, a_i, b_i, rnd_i, rnd_valid_i, mul_out_i, mul_drdy_i,
        output ack_o, err_o, res_o, mul_drdy_o, mul_p1_o, mul_p2_o,
               p_det_o, random_vect_o
    );

    modport master (
        output req_i, a_i, b_i, rnd_i, rnd_valid_i, mul_out_i, mul_drdy_i,
        input  ack_o, err_o, res_o, mul_drdy_o, mul_p1_o, mul_p2_o,
               p_det_o, random_vect_o
    );
endinterface

// File: rtl/mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching upward from one above
// the last-served index (wrapping), with a registered last-served pointer.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int GW    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             update,
    input  logic [GW-1:0]    served,
    output logic [GW-1:0]    grant,
    output logic             grant_valid
);

    logic [GW-1:0] ptr_r;

    // Pick the first requester after the pointer, wrapping at N_REQ-1
    always_comb begin : search
        int cand;
        grant       = {GW{1'b0}};
        grant_valid = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(ptr_r) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end else begin
                cand = cand;
            end
            if (!grant_valid && req[GW'(cand)]) begin
                grant_valid = 1'b1;
                grant       = GW'(cand);
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

    // Last-served pointer; resets to N_REQ-1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= GW'(N_REQ - 1);
        end else if (update) begin
            ptr_r <= served;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one masked multiplier among N_REQ requesters: arbitrates, loads a
// fresh p_det and random mask per operation, issues the operands, waits for
// the result with a timeout and pulses a one-hot ack to the served requester.
module mul_scheduler
    import mul_scheduler_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    mul_scheduler_if.slave bus
);

    localparam int GW    = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t     state_r;
    logic [GW-1:0]    grant_r;
    logic             pdet_done_r;
    logic [IDX_W-1:0] byte_idx_r;
    logic [CNT_W-1:0] wait_cnt_r;

    logic [GW-1:0]    arb_grant_s;
    logic             arb_valid_s;
    logic             arb_update_s;
    logic [N_REQ-1:0] grant_oh_s;

    assign arb_update_s = (state_r == RESP);

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.req_i),
        .update      (arb_update_s),
        .served      (grant_r),
        .grant       (arb_grant_s),
        .grant_valid (arb_valid_s)
    );

    // One-hot form of the latched grant, used for the ack pulse
    always_comb begin
        grant_oh_s          = {N_REQ{1'b0}};
        grant_oh_s[grant_r] = 1'b1;
    end

    // Scheduler FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= IDLE;
            grant_r           <= {GW{1'b0}};
            pdet_done_r       <= 1'b0;
            byte_idx_r        <= {IDX_W{1'b0}};
            wait_cnt_r        <= {CNT_W{1'b0}};
            bus.ack_o         <= {N_REQ{1'b0}};
            bus.err_o         <= 1'b0;
            bus.res_o         <= 16'h0000;
            bus.mul_drdy_o    <= 1'b0;
            bus.mul_p1_o      <= 16'h0000;
            bus.mul_p2_o      <= 16'h0000;
            bus.p_det_o       <= 5'd0;
            bus.random_vect_o <= {MASK_LEN{8'h00}};
        end else begin
            case (state_r)
                IDLE: begin
                    bus.ack_o      <= {N_REQ{1'b0}};
                    bus.err_o      <= 1'b0;
                    bus.mul_drdy_o <= 1'b0;
                    if (|bus.req_i) begin
                        state_r <= ARB;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARB: begin
                    if (arb_valid_s) begin
                        grant_r      <= arb_grant_s;
                        bus.mul_p1_o <= bus.a_i[arb_grant_s];
                        bus.mul_p2_o <= bus.b_i[arb_grant_s];
                        pdet_done_r  <= 1'b0;
                        byte_idx_r   <= {IDX_W{1'b0}};
                        state_r      <= LOAD;
                    end else begin
                        // request withdrawn before the grant was taken
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (!bus.rnd_valid_i) begin
                        state_r <= LOAD;
                    end else if (!pdet_done_r) begin
                        // rejected candidates simply leave pdet_done_r low
                        if (pdet_ok(bus.rnd_i[4:0])) begin
                            bus.p_det_o <= bus.rnd_i[4:0];
                            pdet_done_r <= 1'b1;
                        end else begin
                            pdet_done_r <= 1'b0;
                        end
                    end else begin
                        bus.random_vect_o[byte_idx_r] <= bus.rnd_i;
                        if (byte_idx_r == IDX_W'(MASK_LEN - 1)) begin
                            bus.mul_drdy_o <= 1'b1;
                            state_r        <= ISSUE;
                        end else begin
                            byte_idx_r <= byte_idx_r + IDX_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    // wait_cnt_r counts cycles elapsed since the ISSUE cycle
                    bus.mul_drdy_o <= 1'b0;
                    wait_cnt_r     <= CNT_W'(1);
                    state_r        <= WAIT;
                end
                WAIT: begin
                    if (bus.mul_drdy_i) begin
                        bus.res_o <= bus.mul_out_i;
                        bus.err_o <= 1'b0;
                        bus.ack_o <= grant_oh_s;
                        state_r   <= RESP;
                    end else if (wait_cnt_r >= CNT_W'(TIMEOUT - 1)) begin
                        // RESP lands exactly TIMEOUT cycles after ISSUE
                        bus.res_o <= 16'h0000;
                        bus.err_o <= 1'b1;
                        bus.ack_o <= grant_oh_s;
                        state_r   <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    bus.ack_o <= {N_REQ{1'b0}};
                    bus.err_o <= 1'b0;
                    bus.res_o <= 16'h0000;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_scheduler.sv
// Randomized self-checking bench for mul_scheduler: a transaction-level
// model predicts grant order, p_det, mask, result, error flag and latency.
module tb_mul_scheduler;
    import mul_scheduler_pkg::*;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst;

    mul_scheduler_if #(.N_REQ(N_REQ)) bus ();

    mul_scheduler #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int               cyc = 0;
    logic [15:0]      op_a [N_REQ];
    logic [15:0]      op_b [N_REQ];
    logic [7:0]       byte_q [$];
    logic [N_REQ-1:0] req;
    int               last_served;
    int               issue_cnt = 0;
    logic [15:0]      issue_p1, issue_p2, prod;
    int               mul_cd = 0;
    int               mul_lat = 1;
    bit               mul_never = 1'b0;
    bit               force_drdy = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Multiplier model: answers mul_lat cycles after the issue cycle
    initial begin
        bus.mul_drdy_i = 1'b0;
        bus.mul_out_i  = 16'h0000;
        forever begin
            @(negedge clk);
            bus.mul_drdy_i = 1'b0;
            bus.mul_out_i  = 16'($urandom);
            if (rst) mul_cd = 0;
            if (force_drdy) bus.mul_drdy_i = 1'b1;
            if (mul_cd > 0) begin
                mul_cd--;
                if (mul_cd == 0) begin
                    bus.mul_drdy_i = 1'b1;
                    bus.mul_out_i  = prod;
                end
            end
            if (bus.mul_drdy_o === 1'b1) begin
                issue_cnt++;
                issue_p1 = bus.mul_p1_o;
                issue_p2 = bus.mul_p2_o;
                prod     = 16'(bus.mul_p1_o * bus.mul_p2_o);
                if (!mul_never) mul_cd = mul_lat;
            end
        end
    end

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            int i;
            i = (last + k) % N_REQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic gen_bytes(input int n_rej);
        byte_q.delete();
        for (int i = 0; i < n_rej; i++)
            byte_q.push_back({3'($urandom), 5'(30 + $urandom_range(0, 1))});
        byte_q.push_back({3'($urandom), 5'($urandom_range(0, 29))});
        for (int i = 0; i < MASK_LEN; i++)
            byte_q.push_back(8'($urandom));
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
        end
    endtask

    // Called at a negedge while the DUT is idle/entering arbitration
    task automatic feed_bytes(input int stall_pos, input int stall_len);
        int k;
        int stall_left;
        k = 0;
        stall_left = stall_len;
        @(posedge clk);
        @(posedge clk);
        while (k < byte_q.size()) begin
            @(negedge clk);
            if (k == stall_pos && stall_left > 0) begin
                bus.rnd_valid_i = 1'b0;
                bus.rnd_i       = 8'($urandom);
                stall_left--;
            end else begin
                bus.rnd_i       = byte_q[k];
                bus.rnd_valid_i = 1'b1;
                k++;
            end
        end
        @(negedge clk);
        bus.rnd_valid_i = 1'b0;
        bus.rnd_i       = 8'($urandom);
    endtask

    task automatic do_op(input logic [N_REQ-1:0] new_bits, input int stall_pos, input int stall_len,
                         input int lat, input bit never, input bit hold, input bit drop_mid,
                         output int g);
        int cyc0, rej, exp_lat, issue0;
        logic [4:0]            exp_pdet;
        logic [8*MASK_LEN-1:0] exp_vec;
        logic [15:0]           exp_res;
        logic [N_REQ-1:0]      exp_ack;
        bit got;
        rej = 0;
        while (rej < byte_q.size() && int'(byte_q[rej][4:0]) >= P_DET_MAX) rej++;
        exp_pdet = byte_q[rej][4:0];
        for (int i = 0; i < MASK_LEN; i++)
            exp_vec[8*(MASK_LEN-1-i) +: 8] = byte_q[rej+1+i];
        for (int i = 0; i < N_REQ; i++) begin
            bus.a_i[i] = op_a[i];
            bus.b_i[i] = op_b[i];
        end
        req = req | new_bits;
        bus.req_i = req;
        g = rr_pick(req, last_served);
        exp_ack = '0;
        exp_ack[g] = 1'b1;
        exp_res = never ? 16'h0000 : 16'(op_a[g] * op_b[g]);
        exp_lat = never ? 3 + MASK_LEN + rej + stall_len + TIMEOUT
                        : 4 + MASK_LEN + rej + stall_len + lat;
        mul_lat = lat;
        mul_never = never;
        cyc0 = cyc;
        issue0 = issue_cnt;
        feed_bytes(stall_pos, stall_len);
        if (drop_mid) begin
            req[g] = 1'b0;
            bus.req_i = req;
        end
        got = 1'b0;
        for (int c = 0; c < TIMEOUT + 200 && !got; c++) begin
            @(negedge clk);
            if (bus.ack_o !== '0) got = 1'b1;
        end
        check("ack_seen", got, 1'b1);
        if (got) begin
            check("ack_onehot", bus.ack_o, exp_ack);
            check("err", bus.err_o, never);
            check("res", bus.res_o, exp_res);
            check("latency", cyc - cyc0, exp_lat);
            check("p_det", bus.p_det_o, exp_pdet);
            check("mask", bus.random_vect_o, exp_vec);
            check("p1_stable", bus.mul_p1_o, op_a[g]);
            check("p2_stable", bus.mul_p2_o, op_b[g]);
            check("issue_pulses", issue_cnt - issue0, 1);
            check("issue_p1", issue_p1, op_a[g]);
            check("issue_p2", issue_p2, op_b[g]);
        end
        if (!hold) req[g] = 1'b0;
        bus.req_i = req;
        last_served = g;
        @(negedge clk);
        check("ack_pulse", bus.ack_o, {N_REQ{1'b0}});
        check("err_pulse", bus.err_o, 1'b0);
        byte_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, bus.ack_o, {N_REQ{1'b0}});
        check({tag, "_err"}, bus.err_o, 1'b0);
        check({tag, "_res"}, bus.res_o, 16'h0000);
        check({tag, "_drdy"}, bus.mul_drdy_o, 1'b0);
        check({tag, "_p1"}, bus.mul_p1_o, 16'h0000);
        check({tag, "_p2"}, bus.mul_p2_o, 16'h0000);
        check({tag, "_pdet"}, bus.p_det_o, 5'd0);
        check({tag, "_mask"}, bus.random_vect_o, {MASK_LEN{8'h00}});
    endtask

    initial begin
        int g;
        int issue0;
        int acks;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req = '0;
        bus.req_i = '0;
        bus.rnd_i = 8'h00;
        bus.rnd_valid_i = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.a_i[i] = 16'h0000;
            bus.b_i[i] = 16'h0000;
        end
        last_served = N_REQ - 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // single request with a fixed p_det byte and constant mask
        randomize_operands();
        op_a[0] = 16'hb2f4;
        op_b[0] = 16'hc23f;
        byte_q.delete();
        byte_q.push_back(8'h0c);
        for (int i = 0; i < MASK_LEN; i++) byte_q.push_back(8'hee);
        do_op(4'b0001, -1, 0, 1, 1'b0, 1'b0, 1'b0, g);

        // rejected first candidate
        randomize_operands();
        byte_q.delete();
        byte_q.push_back(8'h1f);
        byte_q.push_back(8'h05);
        for (int i = 0; i < MASK_LEN; i++) byte_q.push_back(8'($urandom));
        do_op(4'b0010, -1, 0, 1, 1'b0, 1'b0, 1'b0, g);

        // random source stalls for 10 cycles mid-load
        randomize_operands();
        gen_bytes(0);
        do_op(4'b0100, 8, 10, 2, 1'b0, 1'b0, 1'b0, g);

        // multiplier never answers
        randomize_operands();
        gen_bytes(0);
        do_op(4'b1000, -1, 0, 1, 1'b1, 1'b0, 1'b0, g);

        // all four held: round-robin order
        for (int k = 0; k < 5; k++) begin
            randomize_operands();
            gen_bytes(0);
            do_op(4'b1111, -1, 0, 1, 1'b0, 1'b1, 1'b0, g);
            check("rr_order", g, exp_order[k]);
        end
        req = '0;
        bus.req_i = req;

        // randomized operations
        for (int k = 0; k < 12; k++) begin
            randomize_operands();
            gen_bytes($urandom_range(0, 2));
            do_op(4'($urandom_range(1, 15)), $urandom_range(1, 15), $urandom_range(0, 4),
                  $urandom_range(1, 6), 1'b0, 1'b0, 1'($urandom_range(0, 1)), g);
        end
        req = '0;
        bus.req_i = req;

        // reset while waiting on the multiplier, then a spurious drdy
        randomize_operands();
        gen_bytes(0);
        for (int i = 0; i < N_REQ; i++) begin
            bus.a_i[i] = op_a[i];
            bus.b_i[i] = op_b[i];
        end
        mul_never = 1'b1;
        issue0 = issue_cnt;
        req = 4'b0100;
        bus.req_i = req;
        feed_bytes(-1, 0);
        for (int c = 0; c < 100 && issue_cnt == issue0; c++) @(negedge clk);
        check("rst_issue_seen", issue_cnt - issue0, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        req = '0;
        bus.req_i = req;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_wait");
        last_served = N_REQ - 1;
        byte_q.delete();
        force_drdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        force_drdy = 1'b0;
        acks = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.ack_o !== '0) acks++;
        end
        check("rst_no_ack", acks, 0);
        mul_never = 1'b0;
        randomize_operands();
        gen_bytes(1);
        do_op(4'b1001, -1, 0, 3, 1'b0, 1'b0, 1'b0, g);
        check("rst_next_grant", g, 0);
        req = '0;
        bus.req_i = req;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_scheduler.md
MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles waiting on multiplier drdy before abort.
REQ-003 SHALL have port clk  in  1  system clock; single clock domain.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_i  in  N_REQ  per-requester request level, held until ack.
REQ-006 SHALL have port a_i / b_i  in  N_REQ x 16  per-requester operands in redundant representation.
REQ-007 SHALL have port ack_o  out  N_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-008 SHALL have port err_o  out  1  one-cycle pulse with ack_o when the operation timed out.
REQ-009 SHALL have port res_o  out  16  result; valid only in the ack_o cycle.
REQ-010 SHALL have port rnd_i / rnd_valid_i  in  8 / 1  random byte stream; byte consumed when valid.
REQ-011 SHALL have multiplier-side ports mul_drdy_o (1), mul_p1_o (16), mul_p2_o (16), p_det_o (p_det_t), random_vect_o (red_poly_t [0:2*(8+d)-1]), all out; mul_out_i (16) and mul_drdy_i (1), both in.

Function
REQ-012 SHALL use FSM states IDLE, ARB, LOAD, ISSUE, WAIT, RESP.
REQ-013 IDLE -> ARB when any req_i bit is high; otherwise stay in IDLE.
REQ-014 ARB: round-robin grant; search starts one above the last-served index and wraps N_REQ-1 -> 0; grant index and operands latched in one cycle; -> LOAD.
REQ-015 LOAD: consume rnd_valid_i bytes; first byte[4:0] becomes candidate p_det; a candidate >= 30 is discarded and the next valid byte is tried; then 2*(8+d) valid bytes fill random_vect_o in index order 0 upward; stall while rnd_valid_i is low; -> ISSUE after the last byte.
REQ-016 ISSUE: mul_drdy_o high for exactly one cycle with mul_p1_o / mul_p2_o = latched operands; -> WAIT.
REQ-017 WAIT: count cycles; mul_drdy_i high -> capture mul_out_i, -> RESP; counter reaching TIMEOUT -> RESP with err flag set, result forced to 16'h0000.
REQ-018 RESP: ack_o[grant]=1 for one cycle, res_o valid, err_o = err flag; -> IDLE; last-served index := grant.
REQ-019 p_det_o, random_vect_o, mul_p1_o and mul_p2_o SHALL stay stable from ISSUE through the RESP cycle.
REQ-020 A req_i bit dropped before ack SHALL NOT abort an operation in flight; the ack is still issued.
REQ-021 mul_drdy_i asserted outside WAIT SHALL be ignored.
REQ-022 At most one operation SHALL be in flight; every operation, including back-to-back operations, reloads fresh p_det and mask.
REQ-023 Minimum latency from a req_i rise in IDLE to ack_o SHALL be 4 + 2*(8+d) + multiplier latency cycles (rnd_valid_i held high, first candidate valid).

Reset
REQ-024 On rst: state=IDLE, ack_o=0, err_o=0, res_o=0, mul_drdy_o=0, mul_p1_o=mul_p2_o=0, p_det_o=0, random_vect_o all zero, last-served=N_REQ-1 (so requester 0 wins first), counters 0.
REQ-025 rst in any state SHALL abandon the operation in one cycle with no ack; a late mul_drdy_i after reset SHALL be ignored.

Structure
REQ-026 p_det_t, red_poly_t, d and the FSM state enum SHALL come from shared package types; the P_DET_MAX=30 constant SHALL be added there.
REQ-027 One sub-module rr_arbiter (N_REQ-wide, combinational grant plus a registered pointer) SHALL be used; p_param_extractor stays outside, driven by p_det_o.

Verification
REQ-028 Single request: req_i=4'b0001, a=16'hb2f4, b=16'hc23f, rnd bytes 8'h0c then 8'hee repeated -> p_det_o=12, every random_vect_o entry 8'hee, ack_o=4'b0001 once, res_o equal to a standalone multiplier with the same inputs.
REQ-029 Contention: req_i=4'b1111 held -> ack order 0,1,2,3,0; no requester acked twice before all others are served.
REQ-030 Rejection: first rnd byte 8'h1f (31), second 8'h05 -> p_det_o=5; one extra LOAD cycle.
REQ-031 Stall: rnd_valid_i low for 10 cycles mid-LOAD -> latency grows by exactly 10; mask contents unchanged.
REQ-032 Timeout: multiplier model never raises drdy -> ack_o with err_o=1, res_o=0 exactly TIMEOUT cycles after ISSUE.
REQ-033 Reset in WAIT, then a spurious mul_drdy_i -> no ack_o, state IDLE, next request served normally.
